// File: rtl/fnn_argmax_select.sv
// fnn_argmax_select
//   Scans NUM_CLASSES signed activations (one per accepted in_valid, class
//   index given by arrival order) and reports the index and value of the
//   largest one. Ties keep the lower index.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle pulse starting a new scan
//   in_valid   in_data holds the next activation
//   in_data    signed activation
//   busy       high while scanning
//   pred       winning class index of the last completed sample
//   pred_valid one-cycle pulse when pred/max_val update
//   max_val    activation value of the winning class
//   err        sticky protocol-error flag
module fnn_argmax_select #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic [IDX_W-1:0]  pred,
    output logic              pred_valid,
    output logic [DATA_W-1:0] max_val,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [IDX_W-1:0]  best, best_n;
    logic [DATA_W-1:0] run_max, run_max_n;
    logic [IDX_W-1:0]  pred_n;
    logic [DATA_W-1:0] max_val_n;
    logic              err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            best    <= '0;
            run_max <= '0;
            pred    <= '0;
            max_val <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            best    <= best_n;
            run_max <= run_max_n;
            pred    <= pred_n;
            max_val <= max_val_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        best_n    = best;
        run_max_n = run_max;
        pred_n    = pred;
        max_val_n = max_val;
        err_n     = err;

        case (state)
            IDLE: begin
                if (start) begin
                    // A clean start clears err; data arriving with start is
                    // dropped and flagged.
                    state_n = SCAN;
                    idx_n   = '0;
                    err_n   = in_valid;
                end else if (in_valid) begin
                    err_n = 1'b1;
                end
            end

            SCAN: begin
                if (start) begin
                    // Restart: discard the partial scan, drop in_data.
                    idx_n = '0;
                    err_n = 1'b1;
                end else if (in_valid) begin
                    if (idx == '0 || $signed(in_data) > $signed(run_max)) begin
                        run_max_n = in_data;
                        best_n    = idx;
                    end
                    if (idx == LAST) begin
                        // The result is committed on the accepting edge so
                        // pred/max_val are already valid during DONE, the
                        // cycle in which pred_valid is high.
                        state_n   = DONE;
                        idx_n     = '0;
                        pred_n    = best_n;
                        max_val_n = run_max_n;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    state_n = SCAN;
                    idx_n   = '0;
                    err_n   = in_valid;
                end else begin
                    state_n = IDLE;
                    if (in_valid) begin
                        err_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy       = (state == SCAN);
    assign pred_valid = (state == DONE);

endmodule

// File: tb/tb_fnn_argmax_select.sv
module tb_fnn_argmax_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        busy;
    logic [3:0]  pred;
    logic        pred_valid;
    logic [15:0] max_val;
    logic        err;

    int tests  = 0;
    int fails  = 0;
    int pv_cnt = 0;

    logic [15:0] vec [10];

    fnn_argmax_select #(
        .DATA_W(16),
        .NUM_CLASSES(10),
        .IDX_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .busy(busy),
        .pred(pred),
        .pred_valid(pred_valid),
        .max_val(max_val),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pred_valid) pv_cnt++;
    endtask

    // Feed the first n entries of vec, with gap idle cycles between elements.
    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            tick();
            in_valid = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_gap", {31'b0, busy}, 32'd1);
                    check("pv_gap", {31'b0, pred_valid}, 32'd0);
                end
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_pred", {28'b0, pred}, 32'd0);
        check("rst_pv", {31'b0, pred_valid}, 32'd0);
        check("rst_max", {16'b0, max_val}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);

        // Basic scan: max 12 first at index 2, tie at index 5 keeps 2.
        vec = '{16'd5, -16'sd3, 16'd12, 16'd7, 16'd0, 16'd12, 16'd1, -16'sd8, 16'd2, 16'd9};
        pv_cnt = 0;
        do_start();
        check("s1_busy", {31'b0, busy}, 32'd1);
        feed(10, 0);
        check("s1_pv", {31'b0, pred_valid}, 32'd1);
        check("s1_pred", {28'b0, pred}, 32'd2);
        check("s1_max", {16'b0, max_val}, 32'd12);
        check("s1_err", {31'b0, err}, 32'd0);
        check("s1_busy_done", {31'b0, busy}, 32'd0);
        tick();
        check("s1_pv_off", {31'b0, pred_valid}, 32'd0);
        check("s1_pv_cnt", pv_cnt, 32'd1);

        // Same data with 3 idle cycles between elements.
        pv_cnt = 0;
        do_start();
        feed(10, 3);
        check("s3_pv", {31'b0, pred_valid}, 32'd1);
        check("s3_pred", {28'b0, pred}, 32'd2);
        check("s3_max", {16'b0, max_val}, 32'd12);
        tick();
        check("s3_pv_cnt", pv_cnt, 32'd1);

        // Restart mid-scan: first 4 elements (max at index 3) discarded.
        pv_cnt = 0;
        vec = '{16'd1, 16'd2, 16'd3, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start();
        feed(4, 0);
        check("s4_pred_hold", {28'b0, pred}, 32'd2);
        check("s4_max_hold", {16'b0, max_val}, 32'd12);
        do_start();
        check("s4_err_restart", {31'b0, err}, 32'd1);
        check("s4_busy", {31'b0, busy}, 32'd1);
        vec = '{16'd10, 16'd20, 16'd30, -16'sd5, 16'd0, 16'd15, 16'd25, 16'd35, 16'd39, 16'd40};
        feed(10, 0);
        check("s4_pred", {28'b0, pred}, 32'd9);
        check("s4_max", {16'b0, max_val}, 32'd40);
        check("s4_err", {31'b0, err}, 32'd1);
        tick();
        check("s4_pv_cnt", pv_cnt, 32'd1);

        // Stray in_valid in IDLE.
        in_valid = 1'b1; in_data = 16'd1000;
        tick();
        in_valid = 1'b0;
        check("s5_err", {31'b0, err}, 32'd1);
        check("s5_pred", {28'b0, pred}, 32'd9);
        check("s5_max", {16'b0, max_val}, 32'd40);
        do_start();
        check("s5_err_clr", {31'b0, err}, 32'd0);

        // Reset after 6 elements.
        pv_cnt = 0;
        vec = '{16'd100, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
        feed(6, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_busy", {31'b0, busy}, 32'd0);
        check("s6_pred", {28'b0, pred}, 32'd0);
        check("s6_max", {16'b0, max_val}, 32'd0);
        check("s6_pv", {31'b0, pred_valid}, 32'd0);
        tick();
        check("s6_pv_cnt", pv_cnt, 32'd0);

        // Fresh scan, all negative: -7 at indices 2 and 3, lower index wins.
        vec = '{-16'sd100, -16'sd50, -16'sd7, -16'sd7, -16'sd900, -16'sd20, -16'sd30, -16'sd40, -16'sd60, -16'sd80};
        pv_cnt = 0;
        do_start();
        feed(10, 0);
        check("s2_pv", {31'b0, pred_valid}, 32'd1);
        check("s2_pred", {28'b0, pred}, 32'd2);
        check("s2_max", {16'b0, max_val}, 32'h0000_FFF9);
        check("s2_err", {31'b0, err}, 32'd0);

        // Start during DONE: accepted, goes straight back to SCAN.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s7_busy", {31'b0, busy}, 32'd1);
        check("s7_err", {31'b0, err}, 32'd0);
        check("s7_pred", {28'b0, pred}, 32'd2);
        check("s7_pv_cnt", pv_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
